// File: rtl/jk_sync_counter_param.sv
// Parametrised modulo-N up/down counter built from per-bit JK cells with synchronous clamped load.
// Optional feature macro: JKCNT_SATURATE_EN (saturate at the count limits instead of wrapping).
module jk_sync_counter_param #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_dl;
    logic [WIDTH-1:0] w_tup;
    logic [WIDTH-1:0] w_tdn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_at_lim;
    logic             w_lim_evt;

    // Out-of-range load values clamp to the top of the count range.
    assign w_dl      = ({1'b0, d} < LP_MOD) ? d : LP_MAX;
    assign w_at_lim  = up_dn ? (r_q == LP_MAX) : (r_q == '0);
    assign w_lim_evt = en & ~load & w_at_lim;

`ifndef JKCNT_SATURATE_EN
    logic [WIDTH-1:0] w_tgt;
    assign w_tgt = up_dn ? '0 : LP_MAX;
`endif

    always_comb begin
        w_tup[0] = 1'b1;
        w_tdn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_tup[i] = w_tup[i-1] & r_q[i-1];
            w_tdn[i] = w_tdn[i-1] & ~r_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_j[i] = 1'b0;
            w_k[i] = 1'b0;
            if (load) begin
                w_j[i] = w_dl[i];
                w_k[i] = ~w_dl[i];
            end else if (w_lim_evt) begin
`ifdef JKCNT_SATURATE_EN
                w_j[i] = 1'b0;
                w_k[i] = 1'b0;
`else
                // Force each cell straight to the wrap target so non-power-of-2 moduli work.
                w_j[i] = w_tgt[i] & ~r_q[i];
                w_k[i] = ~w_tgt[i] & r_q[i];
`endif
            end else if (en) begin
                w_j[i] = up_dn ? w_tup[i] : w_tdn[i];
                w_k[i] = up_dn ? w_tup[i] : w_tdn[i];
            end
        end
    end

    assign w_q_nxt = (w_j & ~r_q) | (~w_k & r_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
`ifdef JKCNT_SATURATE_EN
            r_wrap <= 1'b0;
`else
            r_wrap <= w_lim_evt;
`endif
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;
    assign tc   = w_lim_evt;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_sync_counter_param.sv
// Directed bench for jk_sync_counter_param at WIDTH=4, MODULUS=10 (wrap or saturate build).
module tb_jk_sync_counter_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       tc;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;

    jk_sync_counter_param #(.WIDTH(4), .MODULUS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .up_dn (up_dn),
        .load  (load),
        .d     (d),
        .q     (q),
        .qbar  (qbar),
        .tc    (tc),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] val);
        load = 1'b1;
        d    = val;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        up_dn = 1'b1;
        load  = 1'b0;
        d     = 4'd0;
        #2;
        check("rst_q", q, 0);
        check("rst_qbar", qbar, 15);
        check("rst_wrap", wrap, 0);
        check("rst_tc", tc, 0);
        step();
        rst_n = 1'b1;

        // Up count from 0 through the limit
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("up_q%0d", k), q, k);
            check($sformatf("up_tc%0d", k), tc, (k == 9) ? 1 : 0);
            if (k > 0) check($sformatf("up_wrap%0d", k), wrap, 0);
            step();
        end
`ifdef JKCNT_SATURATE_EN
        check("sat_up_q", q, 9);
        check("sat_up_wrap", wrap, 0);
        step();
        check("sat_up_q2", q, 9);
        check("sat_up_wrap2", wrap, 0);
`else
        check("wrap_up_q", q, 0);
        check("wrap_up_pulse", wrap, 1);
        step();
        check("wrap_up_q1", q, 1);
        check("wrap_up_pulse_end", wrap, 0);
`endif

        // Down count from 0
        do_load(4'd0);
        check("dn_load0", q, 0);
        up_dn = 1'b0;
        #1;
        check("dn_tc0", tc, 1);
        step();
`ifdef JKCNT_SATURATE_EN
        check("sat_dn_q", q, 0);
        check("sat_dn_wrap", wrap, 0);
`else
        check("dn_wrap_q", q, 9);
        check("dn_wrap_pulse", wrap, 1);
        check("dn_tc9", tc, 0);
        step();
        check("dn_q8", q, 8);
        check("dn_wrap_end", wrap, 0);
`endif

        // Load priority and clamping
        up_dn = 1'b1;
        en = 1'b1;
        do_load(4'd6);
        check("load6", q, 6);
        check("load6_wrap", wrap, 0);
        do_load(4'd13);
        check("load13_clamp", q, 9);
        load = 1'b1;
        d = 4'd15;
        #1;
        check("load_tc_masked", tc, 0);
        step();
        load = 1'b0;
        check("load15_clamp", q, 9);
        check("load_wrap_masked", wrap, 0);

        // Hold and direction change
        do_load(4'd5);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold%0d", k), q, 5);
        end
        en = 1'b1;
        up_dn = 1'b1; step(); check("dir_6a", q, 6);
        up_dn = 1'b0; step(); check("dir_5a", q, 5);
        up_dn = 1'b1; step(); check("dir_6b", q, 6);
        up_dn = 1'b0; step(); check("dir_5b", q, 5);

        // Saturate/wrap at the top from 8, then down from 1
        up_dn = 1'b1;
        do_load(4'd8);
        step(); check("top_q9", q, 9);
        step();
`ifdef JKCNT_SATURATE_EN
        check("sat_top_q", q, 9);
        check("sat_top_wrap", wrap, 0);
        check("sat_top_tc", tc, 1);
        step();
        check("sat_top_q2", q, 9);
        check("sat_top_wrap2", wrap, 0);
`else
        check("top_wrap_q", q, 0);
        check("top_wrap_pulse", wrap, 1);
`endif
        do_load(4'd1);
        up_dn = 1'b0;
        step(); check("dn1_q0", q, 0);
        step();
`ifdef JKCNT_SATURATE_EN
        check("sat_dn1_q", q, 0);
        check("sat_dn1_wrap", wrap, 0);
`else
        check("dn1_wrap_q", q, 9);
        check("dn1_wrap_pulse", wrap, 1);
`endif

        // Asynchronous reset mid-count at q=7
        up_dn = 1'b1;
        do_load(4'd6);
        step();
        check("pre_rst_q7", q, 7);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_q", q, 0);
        check("arst_qbar", qbar, 15);
        check("arst_wrap", wrap, 0);
        step();
        check("arst_hold_q", q, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_q1", q, 1);
        check("post_rst_qbar", qbar, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
